// File: rtl/blur_row_scheduler.sv
// blur_row_scheduler
// Sequences one row-streaming pass over the source image SRAM for a single blur or detect
// phase: issues row reads, shifts the line buffer one cycle later, and, once the window of
// cfg_win rows is full, emits result-SRAM writes for each window centre row after the compute
// pipeline latency.
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   i_start      one-cycle pulse that begins a pass (sampled only when idle)
//   i_cfg_win    window height K (odd, 3..MAX_WIN), latched at start
//   i_stall      freezes the pass while high
//   i_abort      terminates the pass, back to idle without done
//   o_rd_en      source SRAM row read issued this cycle
//   o_rd_addr    source SRAM row address
//   o_buf_we     line buffer shifts in the SRAM data returned this cycle
//   o_wr_en      result row valid
//   o_wr_addr    result row address (window centre row)
//   o_busy       pass in progress
//   o_done       one-cycle pulse on pass completion
//   o_cfg_err    one-cycle pulse when start is rejected for an illegal i_cfg_win
module blur_row_scheduler #(
  parameter int unsigned ROWS    = 480,
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned MAX_WIN = 9,
  parameter int unsigned PIPE    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [3:0]        i_cfg_win,
  input  logic              i_stall,
  input  logic              i_abort,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_buf_we,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_cfg_err
);

  localparam int unsigned    CW      = ADDR_W + 1;
  localparam logic [CW-1:0]  LastRow = CW'(ROWS - 1);
  localparam logic [3:0]     MaxWin  = 4'(MAX_WIN);

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_t;

  state_t            r_state;
  logic [3:0]        r_win;
  logic [CW-1:0]     r_half;
  logic [CW-1:0]     r_row;      // next row to read
  logic [CW-1:0]     r_shift;    // buffer shifts done so far
  logic              r_pend;     // read issued, data not yet shifted in
  logic [ADDR_W-1:0] r_rd_addr;  // last address presented to the SRAM
  logic [ADDR_W-1:0] r_wr_addr;  // last result address presented
  logic [PIPE-1:0]   r_vld;
  logic [ADDR_W-1:0] r_tok [PIPE];
  logic              r_done;
  logic              r_cfg_err;

  logic              w_rd_en;
  logic              w_buf_we;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [CW-1:0]     w_shift_nxt;
  logic              w_tok_vld;
  logic [ADDR_W-1:0] w_tok_addr;
  logic [ADDR_W-1:0] w_last_addr;
  logic              w_last_wr;
  logic              w_win_ok;

  // Enables are gated by the live stall so a stalled cycle never issues anything; all state
  // advances only on unstalled edges.
  assign w_rd_en  = (r_state == StRead) && !i_stall;
  assign w_buf_we = r_pend && !i_stall;
  assign w_wr_en  = r_vld[PIPE-1] && !i_stall;

  // While stalled the SRAM keeps seeing the last issued address, so the pending read is still
  // valid when the stall releases.
  assign w_rd_addr = w_rd_en ? r_row[ADDR_W-1:0] : r_rd_addr;
  assign w_wr_addr = w_wr_en ? r_tok[PIPE-1] : r_wr_addr;

  assign w_shift_nxt = r_shift + 1'b1;
  assign w_tok_vld   = w_buf_we && (w_shift_nxt >= {{(CW-4){1'b0}}, r_win});
  // Centre row of the window ending at this shift: (s - 1) - HALF with s = r_shift + 1.
  assign w_tok_addr  = ADDR_W'(r_shift - r_half);
  assign w_last_addr = ADDR_W'(LastRow - r_half);
  assign w_last_wr   = w_wr_en && (r_tok[PIPE-1] == w_last_addr);

  assign w_win_ok = i_cfg_win[0] && (i_cfg_win >= 4'd3) && (i_cfg_win <= MaxWin);

  always_ff @(posedge clk) begin
    if (!rst_n || i_abort) begin
      r_state   <= StIdle;
      r_win     <= '0;
      r_half    <= '0;
      r_row     <= '0;
      r_shift   <= '0;
      r_pend    <= 1'b0;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
      r_vld     <= '0;
      for (int i = 0; i < int'(PIPE); i++) r_tok[i] <= '0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      r_rd_addr <= w_rd_addr;
      r_wr_addr <= w_wr_addr;

      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            if (w_win_ok) begin
              r_state <= StRead;
              r_win   <= i_cfg_win;
              r_half  <= {{(CW-3){1'b0}}, i_cfg_win[3:1]};
              r_row   <= '0;
              r_shift <= '0;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end
        StRead: begin
          if (w_rd_en) begin
            r_row <= r_row + 1'b1;
            if (r_row == LastRow) r_state <= StDrain;
          end
        end
        StDrain: begin
          if (w_last_wr) begin
            r_state   <= StIdle;
            r_done    <= 1'b1;
            r_rd_addr <= '0;
            r_wr_addr <= '0;
          end
        end
        default: r_state <= StIdle;
      endcase

      if (!i_stall) begin
        r_pend <= w_rd_en;
        if (w_buf_we) r_shift <= w_shift_nxt;
        r_vld[0] <= w_tok_vld;
        r_tok[0] <= w_tok_addr;
        for (int i = 1; i < int'(PIPE); i++) begin
          r_vld[i] <= r_vld[i-1];
          r_tok[i] <= r_tok[i-1];
        end
      end
    end
  end

  assign o_rd_en   = w_rd_en;
  assign o_rd_addr = w_rd_addr;
  assign o_buf_we  = w_buf_we;
  assign o_wr_en   = w_wr_en;
  assign o_wr_addr = w_wr_addr;
  assign o_busy    = (r_state != StIdle);
  assign o_done    = r_done;
  assign o_cfg_err = r_cfg_err;

endmodule

// File: tb/tb_blur_row_scheduler.sv
// Testbench for blur_row_scheduler with a 16-row image and a 2-cycle compute pipeline.
// Cycle k is the clock period ending at edge k; start is driven in cycle 0.
module tb_blur_row_scheduler;

  localparam int ROWS    = 16;
  localparam int ADDR_W  = 9;
  localparam int MAX_WIN = 9;
  localparam int PIPE    = 2;

  logic              clk;
  logic              rst_n;
  logic              i_start;
  logic [3:0]        i_cfg_win;
  logic              i_stall;
  logic              i_abort;
  logic              o_rd_en;
  logic [ADDR_W-1:0] o_rd_addr;
  logic              o_buf_we;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr;
  logic              o_busy;
  logic              o_done;
  logic              o_cfg_err;

  blur_row_scheduler #(
    .ROWS    (ROWS),
    .ADDR_W  (ADDR_W),
    .MAX_WIN (MAX_WIN),
    .PIPE    (PIPE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (i_start),
    .i_cfg_win (i_cfg_win),
    .i_stall   (i_stall),
    .i_abort   (i_abort),
    .o_rd_en   (o_rd_en),
    .o_rd_addr (o_rd_addr),
    .o_buf_we  (o_buf_we),
    .o_wr_en   (o_wr_en),
    .o_wr_addr (o_wr_addr),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_cfg_err (o_cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One pass per record: stimulus plus hand-computed pass-level results.
  typedef struct {
    int win;        // cfg_win driven with start in cycle 0
    int ss;         // first stall cycle
    int sl;         // stall length (0 = none)
    int kill;       // cycle in which abort/reset is driven (-1 = none)
    bit kill_rst;   // 1: kill by rst_n, 0: by abort
    int mid;        // cycle of an extra start pulse during the pass (-1 = none)
    bit exp_err;    // start rejected
    int exp_nwr;    // number of writes seen
    int exp_first;  // first write address
    int exp_done;   // done cycle (-1 = none)
  } vec_t;

  typedef struct {
    int addr;
    int cyc;
  } wr_t;

  vec_t vecs[16];
  wr_t  sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cur_row;
  int   cur_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d cyc=%0d got=%0d want=%0d", name, cur_row, cur_cyc, act, exp);
    end
  endtask

  initial begin
    int half;
    int ncyc;
    int n_wr;
    int first_wr;
    int done_cyc;
    int busy_end;
    int lcyc;
    bit legal;
    bit stalled;
    bit live;
    bit e_rd;
    wr_t w;

    //            win ss sl kill rst mid err nwr first done
    vecs[0]  = '{5,  0, 0, -1, 0, -1, 0, 12, 2, 20};
    vecs[1]  = '{5,  5, 3, -1, 0, -1, 0, 12, 2, 23};
    vecs[2]  = '{4,  0, 0, -1, 0, -1, 1, 0, -1, -1};
    vecs[3]  = '{11, 0, 0, -1, 0, -1, 1, 0, -1, -1};
    vecs[4]  = '{1,  0, 0, -1, 0, -1, 1, 0, -1, -1};
    vecs[5]  = '{3,  0, 0, -1, 0, 10, 0, 14, 1, 20};
    vecs[6]  = '{5,  0, 0,  9, 0, -1, 0, 2,  2, -1};
    vecs[7]  = '{5,  0, 0, -1, 0, -1, 0, 12, 2, 20};
    vecs[8]  = '{5,  0, 0,  6, 1, -1, 0, 0, -1, -1};
    vecs[9]  = '{5,  0, 0, -1, 0, -1, 0, 12, 2, 20};
    vecs[10] = '{9,  0, 0,  0, 0, -1, 0, 0, -1, -1};
    vecs[11] = '{9,  0, 0, -1, 0, -1, 0, 8,  4, 20};
    vecs[12] = '{7,  1, 2, -1, 0, -1, 0, 10, 3, 22};
    vecs[13] = '{5, 18, 2, -1, 0, -1, 0, 12, 2, 22};
    vecs[14] = '{5, 20, 2, -1, 0, -1, 0, 12, 2, 20};
    vecs[15] = '{15, 0, 0, -1, 0, -1, 1, 0, -1, -1};

    cur_row   = -1;
    cur_cyc   = 0;
    rst_n     = 1'b0;
    i_start   = 1'b0;
    i_cfg_win = 4'd0;
    i_stall   = 1'b0;
    i_abort   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_rd_en", 32'(o_rd_en), 0);
    chk("rst_rd_addr", 32'(o_rd_addr), 0);
    chk("rst_buf_we", 32'(o_buf_we), 0);
    chk("rst_wr_en", 32'(o_wr_en), 0);
    chk("rst_wr_addr", 32'(o_wr_addr), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_cfg_err", 32'(o_cfg_err), 0);

    for (int r = 0; r < 16; r++) begin
      cur_row  = r;
      legal    = !vecs[r].exp_err;
      half     = (vecs[r].win - 1) / 2;
      n_wr     = 0;
      first_wr = -1;
      done_cyc = -1;
      busy_end = ROWS + 1 + PIPE;
      if (vecs[r].sl > 0 && vecs[r].ss >= 1 && vecs[r].ss <= ROWS + 1 + PIPE)
        busy_end += vecs[r].sl;
      if (vecs[r].exp_done >= 0) ncyc = vecs[r].exp_done + 2;
      else if (vecs[r].kill >= 0) ncyc = vecs[r].kill + 4;
      else ncyc = 4;

      for (int cyc = 0; cyc <= ncyc; cyc++) begin
        cur_cyc = cyc;
        @(posedge clk);
        #1;
        stalled   = vecs[r].sl > 0 && cyc >= vecs[r].ss && cyc < vecs[r].ss + vecs[r].sl;
        i_start   = (cyc == 0) || (cyc == vecs[r].mid);
        i_cfg_win = (cyc == 0) ? 4'(vecs[r].win) : (cyc == vecs[r].mid) ? 4'd7 : 4'd15;
        i_stall   = stalled;
        i_abort   = !vecs[r].kill_rst && (cyc == vecs[r].kill);
        rst_n     = !(vecs[r].kill_rst && (cyc == vecs[r].kill));

        if (cyc == 0 && legal) begin
          for (int c = half; c <= ROWS - 1 - half; c++) begin
            w.addr = c;
            w.cyc  = c + half + 2 + PIPE;
            if (vecs[r].sl > 0 && w.cyc >= vecs[r].ss) w.cyc += vecs[r].sl;
            sb_q.push_back(w);
          end
        end
        #1;

        live = (vecs[r].kill < 0) || (cyc <= vecs[r].kill);
        lcyc = (vecs[r].sl > 0 && cyc >= vecs[r].ss + vecs[r].sl) ? cyc - vecs[r].sl : cyc;
        e_rd = live && legal && !stalled && lcyc >= 1 && lcyc <= ROWS;

        chk("busy", 32'(o_busy), 32'(live && legal && cyc >= 1 && cyc <= busy_end));
        chk("done", 32'(o_done), 32'(live && legal && cyc == busy_end + 1));
        chk("cfg_err", 32'(o_cfg_err), 32'(live && vecs[r].exp_err && cyc == 1));
        chk("rd_en", 32'(o_rd_en), 32'(e_rd));
        chk("buf_we", 32'(o_buf_we),
            32'(live && legal && !stalled && lcyc >= 2 && lcyc <= ROWS + 1));
        if (e_rd) begin
          chk("rd_addr", 32'(o_rd_addr), 32'(lcyc - 1));
        end else if (!live) begin
          chk("kill_rd_addr", 32'(o_rd_addr), 0);
          chk("kill_wr_addr", 32'(o_wr_addr), 0);
          chk("kill_wr_en", 32'(o_wr_en), 0);
        end else if (stalled && legal && vecs[r].ss >= 2 && vecs[r].ss - 1 <= ROWS) begin
          chk("stall_rd_addr", 32'(o_rd_addr), 32'(vecs[r].ss - 2));
        end

        if (o_wr_en === 1'b1) begin
          n_wr++;
          if (first_wr < 0) first_wr = int'(o_wr_addr);
          if (sb_q.size() == 0) begin
            chk("wr_unexpected", 1, 0);
          end else begin
            w = sb_q.pop_front();
            chk("wr_addr", 32'(o_wr_addr), 32'(w.addr));
            chk("wr_cycle", 32'(cyc), 32'(w.cyc));
          end
        end
        if (o_done === 1'b1) done_cyc = cyc;
        if (cyc == vecs[r].kill) sb_q.delete();
      end

      cur_cyc = -1;
      chk("n_writes", 32'(n_wr), 32'(vecs[r].exp_nwr));
      if (vecs[r].exp_nwr > 0) chk("first_wr_addr", 32'(first_wr), 32'(vecs[r].exp_first));
      chk("done_cycle", 32'(done_cyc), 32'(vecs[r].exp_done));
      chk("writes_missing", 32'(sb_q.size()), 0);
      sb_q.delete();
      @(posedge clk);
      #1;
      i_start   = 1'b0;
      i_stall   = 1'b0;
      i_abort   = 1'b0;
      rst_n     = 1'b1;
      i_cfg_win = 4'd0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
